// File: rtl/io_pkg.sv
// io_pkg: shared address map, register offsets and FSM encoding for io_responder.
// Contents:
//   RAM_BASE, PERIPH_BASE        base addresses of the RAM and peripheral window
//   GPIO_OUT .. TIMER_CMP        byte offsets inside the peripheral window
//   state_t                      responder FSM encoding (IDLE, WAIT, RESP)
//   UNMAPPED_RDATA               value returned for reads that hit nothing
package io_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h8000_0000;

    localparam logic [3:0] GPIO_OUT  = 4'h0;
    localparam logic [3:0] GPIO_IN   = 4'h4;
    localparam logic [3:0] TIMER_CNT = 4'h8;
    localparam logic [3:0] TIMER_CMP = 4'hC;

    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/io_timer.sv
// io_timer: free-running 32-bit counter with compare register and level irq.
// Ports:
//   clock, rst        clock and asynchronous active-high reset
//   wr_en, wr_sel     write strobe; wr_sel=0 selects TIMER_CNT, 1 selects TIMER_CMP
//   wdata             write data
//   rd_sel            read select, same encoding as wr_sel
//   rdata_c           combinational read data
//   irq               registered (cnt >= cmp), unsigned
// Only instantiated when IO_RESP_TIMER_EN is defined.
module io_timer (
    input  logic        clock,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wdata,
    input  logic        rd_sel,
    output logic [31:0] rdata_c,
    output logic        irq
);

    logic [31:0] cnt;
    logic [31:0] cmp;

    // A CNT write replaces the increment for that cycle; counting resumes from it.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt <= 32'h0000_0000;
            cmp <= 32'hFFFF_FFFF;
            irq <= 1'b0;
        end else begin
            if (wr_en && !wr_sel) begin
                cnt <= wdata;
            end else begin
                cnt <= cnt + 32'd1;
            end
            if (wr_en && wr_sel) begin
                cmp <= wdata;
            end
            irq <= (cnt >= cmp);
        end
    end

    assign rdata_c = rd_sel ? cmp : cnt;

endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped bus target serving word RAM and a peripheral window.
// Parameters:
//   RAM_WORDS    RAM depth in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra cycles between request acceptance and response (0..15)
// Ports:
//   clock, rst          clock and asynchronous active-high reset
//   i_ioaddr, i_iodat   byte address and write data from the master
//   i_rd, i_wr          read / write request, held until o_ready
//   o_iodat             read data, zero whenever o_ready is low
//   o_ready, o_err      one-cycle completion pulse and its error flag
//   i_gpio, o_gpio      asynchronous GPIO inputs, GPIO output register
//   o_irq               timer interrupt (level)
// Build option: define IO_RESP_TIMER_EN to include the compare timer.
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned RAM_WORDS   = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] i_ioaddr,
    input  logic [31:0] i_iodat,
    input  logic        i_rd,
    input  logic        i_wr,
    output logic [31:0] o_iodat,
    output logic        o_ready,
    output logic        o_err,
    input  logic [7:0]  i_gpio,
    output logic [7:0]  o_gpio,
    output logic        o_irq
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wcnt, wcnt_nxt;
    logic              accept, commit;
    logic              ready_nxt, err_nxt;
    logic [31:0]       rdata_nxt, rd_mux;

    logic [31:0] addr_q, wdata_q;
    logic        rd_q, wr_q;

    logic [31:0] acc_addr, acc_wdata;
    logic        acc_wr;
    logic [3:0]  acc_off;
    logic        acc_ram_hit, acc_periph_hit;
    logic [AW-1:0] ram_idx;

    logic        wr_hit, ram_we, gpio_we;
    logic [7:0]  gpio_out, gpio_s1, gpio_s2;
    logic [31:0] ram [RAM_WORDS];
    logic [31:0] ram_q;
    logic [31:0] tmr_rdata;

    // Live request in IDLE (so a zero-wait write can commit immediately), latched copy afterwards.
    always_comb begin
        acc_addr       = (state == IDLE) ? i_ioaddr : addr_q;
        acc_wdata      = (state == IDLE) ? i_iodat  : wdata_q;
        acc_wr         = (state == IDLE) ? i_wr     : wr_q;
        acc_off        = {acc_addr[3:2], 2'b00};
        acc_ram_hit    = (acc_addr >> (AW + 2)) == (RAM_BASE >> (AW + 2));
        acc_periph_hit = (acc_addr[31:4] == PERIPH_BASE[31:4]);
        ram_idx        = acc_addr[AW+1:2];
    end

    // Read data mux, evaluated in RESP from the latched address.
    always_comb begin
        rd_mux = UNMAPPED_RDATA;
        if (acc_ram_hit) begin
            rd_mux = ram_q;
        end else if (acc_periph_hit) begin
            case (acc_off)
                GPIO_OUT:             rd_mux = {24'h0, gpio_out};
                GPIO_IN:              rd_mux = {24'h0, gpio_s2};
                TIMER_CNT, TIMER_CMP: rd_mux = tmr_rdata;
                default:              rd_mux = UNMAPPED_RDATA;
            endcase
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        accept    = 1'b0;
        ready_nxt = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = UNMAPPED_RDATA;
        case (state)
            IDLE: begin
                if (i_rd || i_wr) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES != 0) begin
                        state_nxt = WAIT;
                        wcnt_nxt  = WAIT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (wcnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    wcnt_nxt = wcnt - WAIT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
                err_nxt   = (rd_q && wr_q) || (addr_q[1:0] != 2'b00) ||
                            !(acc_ram_hit || acc_periph_hit);
                if (!wr_q) begin
                    rdata_nxt = rd_mux;
                end
            end
            default: state_nxt = IDLE;
        endcase
        commit = (state_nxt == RESP) && (state != RESP);
    end

    // Writes land on the edge entering RESP; rst gates the RAM, which has no reset.
    assign wr_hit  = commit && acc_wr && !rst;
    assign ram_we  = wr_hit && acc_ram_hit;
    assign gpio_we = wr_hit && acc_periph_hit && (acc_off == GPIO_OUT);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wcnt     <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            o_iodat  <= 32'h0;
            o_ready  <= 1'b0;
            o_err    <= 1'b0;
            gpio_out <= 8'h00;
            gpio_s1  <= 8'h00;
            gpio_s2  <= 8'h00;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            if (accept) begin
                addr_q  <= i_ioaddr;
                wdata_q <= i_iodat;
                rd_q    <= i_rd;
                wr_q    <= i_wr;
            end
            o_iodat <= rdata_nxt;
            o_ready <= ready_nxt;
            o_err   <= err_nxt;
            if (gpio_we) begin
                gpio_out <= acc_wdata[7:0];
            end
            gpio_s1 <= i_gpio;
            gpio_s2 <= gpio_s1;
        end
    end

    // Synchronous RAM; the word read on the edge entering RESP is used in RESP.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_idx] <= acc_wdata;
        end
        ram_q <= ram[ram_idx];
    end

    assign o_gpio = gpio_out;

`ifdef IO_RESP_TIMER_EN
    logic tmr_we;
    logic tmr_irq;

    assign tmr_we = wr_hit && acc_periph_hit && acc_off[3];

    io_timer u_timer (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (tmr_we),
        .wr_sel  (acc_off[2]),
        .wdata   (acc_wdata),
        .rd_sel  (acc_off[2]),
        .rdata_c (tmr_rdata),
        .irq     (tmr_irq)
    );

    assign o_irq = tmr_irq;
`else
    assign tmr_rdata = 32'h0000_0000;
    assign o_irq     = 1'b0;
`endif

endmodule
